tri_fetch_seq: RTL
==================

// Module: tri_fetch_seq
// PURPOSE
// - Upstream sequencer for the triangle reader. On start, it walks triangle indices 0..ntris-1.
// - Issues read/index requests to the reader, holding each until done, and captures the 288-bit triangle.
// - Buffers triangles in a small FIFO and streams them to the ray-triangle intersection stage over valid/ready.
// PARAMETERS
// - FIFO_DEPTH   4    output FIFO entries (power of 2, >=2)
// - IDX_W        32   width of triangle index and count
// PORTS
// - clk          in   1          system clock
// - reset        in   1          synchronous, active-high reset
// - start        in   1          1-cycle pulse: begin a pass; ignored while busy=1
// - ntris        in   IDX_W      triangle count; sampled on accepted start
// - busy         out  1          pass in progress
// - pass_done    out  1          1-cycle pulse: last triangle popped from FIFO
// - rd_read      out  1          request to reader; held until rd_done
// - rd_index     out  IDX_W      triangle index; held until rd_done
// - rd_data      in   TRI_W      triangle words; valid only when rd_done=1
// - rd_done      in   1          1-cycle completion pulse from reader
// - out_valid    out  1          FIFO head valid
// - out_ready    in   1          consumer accepts head
// - out_data     out  TRI_W      triangle (9 x 32-bit dwords)
// - out_index    out  IDX_W      index of out_data
// - out_last     out  1          out_data is triangle ntris-1
// - stat_hits    out  32         see CONFIGURATION
// - stat_misses  out  32         see CONFIGURATION
// BEHAVIOUR
// - Reset values: busy=0, pass_done=0, rd_read=0, rd_index=0, out_valid=0, stats=0. FIFO is flushed and the FSM goes to IDLE.
// - Every output is registered. The reader shares clk and reset.
// - IDLE: on start with ntris==0, pulse pass_done the next cycle and stay in IDLE. With ntris!=0, latch ntris, set idx=0, and go to REQ, or to STALL if the FIFO is full.
// - REQ: rd_read=1, rd_index=idx, both stable. On rd_done, push {rd_data, idx, idx==ntris-1} into the FIFO in the same cycle.
// - REQ exit when the pushed triangle is the last: go to DRAIN and drop rd_read.
// - REQ exit otherwise: set idx=idx+1. Go to REQ if post-push count<FIFO_DEPTH; else go to STALL with rd_read=0.
// - Re-asserting rd_read the cycle after rd_done is legal; the reader samples read in its idle state.
// - STALL: rd_read=0. Go to REQ in the cycle the FIFO count drops below FIFO_DEPTH.
// - DRAIN: wait for the FIFO to empty. On the pop of the out_last entry, pulse pass_done, clear busy, go to IDLE.
// - Overflow is impossible by construction: REQ is entered only with a free slot. rd_done outside REQ is ignored (assertion).
// - FIFO: out_valid=!empty. A pop occurs when out_valid&&out_ready. There is no bypass: a push into an empty FIFO gives out_valid on the next cycle.
// - Simultaneous push and pop leave the count unchanged, including at full and at count 1. Pointers wrap modulo FIFO_DEPTH.
// - Throughput on cache hits: 1 triangle per 2 cycles (reader compare + idle).
// - Reset mid-pass: immediate abort to IDLE. rd_read drops the next cycle, FIFO contents are lost, no pass_done pulse.
// - idx counter width is IDX_W. ntris=2^IDX_W-1 must not wrap, because the last-compare runs before the increment.
// CONFIGURATION
// - TRI_FETCH_STATS_EN defined: stat_hits/stat_misses count completed reads.
// - A hit is rd_done exactly 1 cycle after rd_read first rises for that index; any later rd_done is a miss.
// - Both counters clear on an accepted start and saturate at 32'hFFFF_FFFF.
// - TRI_FETCH_STATS_EN undefined: the ports remain, tied to 0, and no counters are synthesised.
// STRUCTURE
// - Package tri_pkg: NDWORDS=9, TRI_W=32*NDWORDS, typedef logic [TRI_W-1:0] tri_t.
// - tri_pkg also holds typedef struct {tri_t data; logic [IDX_W-1:0] idx; logic last;} tri_entry_t and the FSM state enum.
// - Sub-module tri_fifo: synchronous FIFO of tri_entry_t with count output, parameter DEPTH. It is reused by later stages.
// TESTING
// - Reset, then start with ntris=0: pass_done pulse 1 cycle later; rd_read never rises; busy stays 0.
// - ntris=3, out_ready=1, reader model always hits (done 1 cycle after read): rd_index 0,1,2 in order.
// - In that run, out_index 0,1,2 appear with out_last only on 2, followed by a single pass_done pulse.
// - ntris=8, FIFO_DEPTH=4, out_ready=0: exactly 4 rd_done accepted, then rd_read=0 in STALL.
// - Then raise out_ready: remaining 4 are fetched and all 8 are delivered in order with no loss or duplication.
// - Miss latency of 20 cycles on index 1: rd_read/rd_index=1 held stable for all 20 cycles.
// - With TRI_FETCH_STATS_EN: stat_hits=2 and stat_misses=1 at the end (ntris=3).
// - Reset asserted in REQ on index 5 of 10: next cycle rd_read=0, out_valid=0, busy=0.
// - A following start with ntris=2 restarts cleanly at index 0.
// - Random out_ready at 50% with ntris=64: the scoreboard checks order, indices, out_last and count=64.
// - With TRI_FETCH_STATS_EN, also check stat_hits+stat_misses=64.

Source files
------------

// File: rtl/tri_pkg.sv
// Shared types for the triangle fetch path: triangle payload, FIFO entry and sequencer states.
package tri_pkg;

   localparam int unsigned NDWORDS     = 9;
   localparam int unsigned TRI_W       = 32 * NDWORDS;
   // Index width carried in a FIFO entry; tri_fetch_seq's IDX_W must match it.
   localparam int unsigned ENTRY_IDX_W = 32;

   typedef logic [TRI_W-1:0] tri_t;

   typedef struct packed {
      tri_t                   data;
      logic [ENTRY_IDX_W-1:0] idx;
      logic                   last;
   } tri_entry_t;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StStall,
      StDrain
   } fetch_state_e;

endpackage

// File: rtl/tri_fetch_seq_if.sv
// Reader request bus plus the triangle output stream of tri_fetch_seq.
// master = sequencer side, slave = reader / intersection-stage side.
interface tri_fetch_seq_if #(
   parameter int unsigned IDX_W = 32
) ();

   logic               rd_read;
   logic [IDX_W-1:0]   rd_index;
   tri_pkg::tri_t      rd_data;
   logic               rd_done;

   logic               out_valid;
   logic               out_ready;
   tri_pkg::tri_t      out_data;
   logic [IDX_W-1:0]   out_index;
   logic               out_last;

   modport master (
      output rd_read, rd_index, out_valid, out_data, out_index, out_last,
      input  rd_data, rd_done, out_ready
   );

   modport slave (
      input  rd_read, rd_index, out_valid, out_data, out_index, out_last,
      output rd_data, rd_done, out_ready
   );

endinterface

// File: rtl/tri_fifo.sv
// Synchronous FIFO of tri_entry_t with occupancy count. No bypass: a push into an
// empty FIFO shows valid on the following cycle. Push while full is accepted only
// together with a pop.
module tri_fifo
   import tri_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = PtrW + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            push,
   input  tri_entry_t      wdata,
   input  logic            pop,
   output tri_entry_t      head,
   output logic            valid,
   output logic [CntW-1:0] count
);

   tri_entry_t      mem [DEPTH];
   logic [PtrW-1:0] wptr_q, rptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            valid_q;
   logic            do_push, do_pop;

   assign do_pop  = pop && valid_q;
   assign do_push = push && ((count_q != CntW'(DEPTH)) || do_pop);

   // Occupancy after this cycle's push/pop.
   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
         count_d = count_q - CntW'(1);
      end
   end

   // Pointers, count and registered valid; pointers wrap modulo DEPTH.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PtrW'(1);
         if (do_pop)  rptr_q <= rptr_q + PtrW'(1);
         count_q <= count_d;
         valid_q <= (count_d != '0);
      end
   end

   // Storage; contents are don't-care once pointers are reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q] <= wdata;
   end

   assign head  = mem[rptr_q];
   assign valid = valid_q;
   assign count = count_q;

endmodule

// File: rtl/tri_fetch_seq.sv
// Triangle fetch sequencer: walks indices 0..ntris-1, requests each triangle from
// the reader, buffers results in tri_fifo and streams them downstream.
// Optional feature macro: TRI_FETCH_STATS_EN (hit/miss counters on reader completions).
module tri_fetch_seq
   import tri_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned IDX_W      = ENTRY_IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [IDX_W-1:0] ntris,
   output logic             busy,
   output logic             pass_done,
   output logic [31:0]      stat_hits,
   output logic [31:0]      stat_misses,
   tri_fetch_seq_if.master  bus
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e     state_q;
   logic             busy_q, pass_done_q, rd_read_q;
   logic [IDX_W-1:0] rd_index_q, ntris_q;

   tri_entry_t       push_entry, head;
   logic             head_valid;
   logic [CntW-1:0]  fifo_cnt, cnt_post;
   logic             fifo_push, fifo_pop, is_last, room_post;

   // Last compare happens before the increment, so ntris = 2^IDX_W-1 never wraps.
   assign is_last   = (rd_index_q == ntris_q - IDX_W'(1));
   assign fifo_push = (state_q == StReq) && bus.rd_done;
   assign fifo_pop  = head_valid && bus.out_ready;
   assign cnt_post  = fifo_cnt + CntW'(fifo_push) - CntW'(fifo_pop);
   assign room_post = (cnt_post < CntW'(FIFO_DEPTH));

   // Entry captured from the reader in the rd_done cycle.
   always_comb begin
      push_entry      = '0;
      push_entry.data = bus.rd_data;
      push_entry.idx  = rd_index_q;
      push_entry.last = is_last;
   end

   tri_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (push_entry),
      .pop   (fifo_pop),
      .head  (head),
      .valid (head_valid),
      .count (fifo_cnt)
   );

   // Sequencer FSM with registered request and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         pass_done_q <= 1'b0;
         rd_read_q   <= 1'b0;
         rd_index_q  <= '0;
         ntris_q     <= '0;
      end else begin
         pass_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  if (ntris == '0) begin
                     pass_done_q <= 1'b1;
                  end else begin
                     ntris_q    <= ntris;
                     rd_index_q <= '0;
                     busy_q     <= 1'b1;
                     if (fifo_cnt < CntW'(FIFO_DEPTH)) begin
                        state_q   <= StReq;
                        rd_read_q <= 1'b1;
                     end else begin
                        state_q <= StStall;
                     end
                  end
               end
            end
            StReq: begin
               if (bus.rd_done) begin
                  if (is_last) begin
                     state_q   <= StDrain;
                     rd_read_q <= 1'b0;
                  end else begin
                     rd_index_q <= rd_index_q + IDX_W'(1);
                     // rd_read stays high: next request issues back-to-back.
                     if (!room_post) begin
                        state_q   <= StStall;
                        rd_read_q <= 1'b0;
                     end
                  end
               end
            end
            StStall: begin
               if (room_post) begin
                  state_q   <= StReq;
                  rd_read_q <= 1'b1;
               end
            end
            StDrain: begin
               if (fifo_pop && head.last) begin
                  state_q     <= StIdle;
                  busy_q      <= 1'b0;
                  pass_done_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign busy          = busy_q;
   assign pass_done     = pass_done_q;
   assign bus.rd_read   = rd_read_q;
   assign bus.rd_index  = rd_index_q;
   assign bus.out_valid = head_valid;
   assign bus.out_data  = head.data;
   assign bus.out_index = head.idx;
   assign bus.out_last  = head.last;

`ifdef TRI_FETCH_STATS_EN
   logic             prev_read_q, first_q;
   logic [IDX_W-1:0] prev_index_q;
   logic [31:0]      hits_q, misses_q;

   // A completion is a hit when it lands the cycle after the request's first cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_read_q  <= 1'b0;
         prev_index_q <= '0;
         first_q      <= 1'b0;
         hits_q       <= '0;
         misses_q     <= '0;
      end else begin
         prev_read_q  <= rd_read_q;
         prev_index_q <= rd_index_q;
         first_q      <= rd_read_q && !(prev_read_q && (prev_index_q == rd_index_q));
         if (start && (state_q == StIdle)) begin
            hits_q   <= '0;
            misses_q <= '0;
         end else if (fifo_push) begin
            if (first_q) begin
               if (hits_q != '1) hits_q <= hits_q + 32'd1;
            end else begin
               if (misses_q != '1) misses_q <= misses_q + 32'd1;
            end
         end
      end
   end

   assign stat_hits   = hits_q;
   assign stat_misses = misses_q;
`else
   assign stat_hits   = '0;
   assign stat_misses = '0;
`endif

`ifndef SYNTHESIS
   rd_done_in_req_a: assert property (@(posedge clk) disable iff (reset)
      bus.rd_done |-> (state_q == StReq));
`endif

endmodule
